// File: rtl/i2c_cmd_engine_pkg.sv
// Shared definitions for the I2C command engine: operation codes, the board's
// known device addresses, the FSM state encoding (8 bits wide so it can be
// exported on a debug bus unchanged) and the on-bus address byte helper.
package i2c_pkg;

  localparam logic READ_OP  = 1'b1;
  localparam logic WRITE_OP = 1'b0;

  // Device addresses as used by the sequencers (bit0 is replaced by R/W on the bus)
  localparam logic [7:0] ID_PWR_EXP  = 8'h42;
  localparam logic [7:0] ID_MUX_A    = 8'hE0;
  localparam logic [7:0] ID_MUX_B    = 8'hE4;
  localparam logic [7:0] ID_QSFP_SB  = 8'h40;
  localparam logic [7:0] ID_QSFP_EEP = 8'hA0;

  localparam int STATE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 8'h00,
    ST_START   = 8'h01,
    ST_TX_BYTE = 8'h02,
    ST_ACK_RX  = 8'h03,
    ST_RSTART  = 8'h04,
    ST_RX_BYTE = 8'h05,
    ST_NACK_TX = 8'h06,
    ST_STOP    = 8'h07,
    ST_DONE    = 8'h08
  } state_t;

  // Address byte as it appears on the wire: device address with R/W in bit0
  function automatic logic [7:0] bus_id(input logic [7:0] id, input logic rw);
    return {id[7:1], rw};
  endfunction

endpackage

// File: rtl/i2c_cmd_engine_if.sv
// IO_CONTROL command interface between the sequencers (master) and the
// I2C command engine (slave), including the engine's status flags.
interface i2c_cmd_engine_if;
  import i2c_pkg::*;

  logic       IO_CONTROL_PULSE;
  logic       IO_CONTROL_RW;
  logic [7:0] IO_CONTROL_ID;
  logic [7:0] IO_ADDR_ADDR;
  logic [7:0] IO_WDATA_WDATA;
  logic [7:0] IO_RDATA_RDATA;
  logic       IO_CONTROL_CMPLT;
  logic       busy;
  logic       ack_err;

  modport master (
    output IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA,
    input  IO_RDATA_RDATA, IO_CONTROL_CMPLT, busy, ack_err
  );

  modport slave (
    input  IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA,
    output IO_RDATA_RDATA, IO_CONTROL_CMPLT, busy, ack_err
  );

endinterface

// File: rtl/i2c_cmd_engine_qtick.sv
// Quarter-bit tick generator: one tick every CLK_DIV clk cycles. 'clear'
// restarts the period, 'hold' freezes it while a target stretches SCL.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: restarts on clear, freezes on hold, wraps after LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !clear && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_cmd_engine.sv
// Single-register I2C transaction engine, responder on the IO_CONTROL command
// interface and master on one open-drain SCL/SDA bus.
// Optional build macro I2C_CLK_STRETCH_EN: when defined, the quarter timing
// freezes while SCL is released but held low by a target (clock stretching);
// when undefined scl_i is ignored.
module i2c_cmd_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_cmd_engine_if.slave  io,
  output logic             scl_t,
  output logic             sda_t,
  input  logic             scl_i,
  input  logic             sda_i
);

  state_t     state, state_nxt;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic [1:0] phase;
  logic       rw_q;
  logic [7:0] id_q, addr_q, wdata_q;
  logic [7:0] tx_byte, rx_byte, rdata_q;
  logic       ack_err_q, nack_q;
  logic       tick, hold, slot_end, sample, accept;
  logic       scl_nxt, sda_nxt, scl_mid;

  assign accept   = (state == ST_IDLE) && io.IO_CONTROL_PULSE;
  assign slot_end = tick && (qtr == 2'd3);
  assign sample   = tick && (qtr == 2'd1);
  assign scl_mid  = (qtr == 2'd1) || (qtr == 2'd2);

`ifdef I2C_CLK_STRETCH_EN
  assign hold = scl_t && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold = 1'b0;
`endif

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE),
    .hold  (hold),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: slots advance on the last quarter tick; a NACK jumps to STOP
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (io.IO_CONTROL_PULSE) state_nxt = ST_START;
      ST_START:   if (slot_end) state_nxt = ST_TX_BYTE;
      ST_TX_BYTE: if (slot_end && bit_cnt == 3'd0) state_nxt = ST_ACK_RX;
      ST_ACK_RX: begin
        if (slot_end) begin
          if (nack_q)              state_nxt = ST_STOP;
          else if (phase == 2'd0)  state_nxt = ST_TX_BYTE;
          else if (phase == 2'd1)  state_nxt = rw_q ? ST_RSTART : ST_TX_BYTE;
          else                     state_nxt = rw_q ? ST_RX_BYTE : ST_STOP;
        end
      end
      ST_RSTART:  if (slot_end) state_nxt = ST_TX_BYTE;
      ST_RX_BYTE: if (slot_end && bit_cnt == 3'd0) state_nxt = ST_NACK_TX;
      ST_NACK_TX: if (slot_end) state_nxt = ST_STOP;
      ST_STOP:    if (slot_end) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: request latch, quarter/bit counters, byte loading, ACK and data sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qtr       <= 2'd0;
      bit_cnt   <= 3'd7;
      phase     <= 2'd0;
      rw_q      <= WRITE_OP;
      id_q      <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      tx_byte   <= 8'h00;
      rx_byte   <= 8'h00;
      rdata_q   <= 8'h00;
      ack_err_q <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      if (accept) begin
        rw_q      <= io.IO_CONTROL_RW;
        id_q      <= io.IO_CONTROL_ID;
        addr_q    <= io.IO_ADDR_ADDR;
        wdata_q   <= io.IO_WDATA_WDATA;
        ack_err_q <= 1'b0;
        nack_q    <= 1'b0;
      end
      if (tick)                  qtr <= qtr + 2'd1;
      else if (state == ST_IDLE) qtr <= 2'd0;
      if (sample && state == ST_ACK_RX) begin
        nack_q <= sda_i;
        if (sda_i) ack_err_q <= 1'b1;
      end
      if (sample && state == ST_RX_BYTE) rx_byte <= {rx_byte[6:0], sda_i};
      if (slot_end) begin
        case (state)
          ST_START: begin
            tx_byte <= bus_id(id_q, WRITE_OP);
            bit_cnt <= 3'd7;
            phase   <= 2'd0;
          end
          ST_TX_BYTE: bit_cnt <= bit_cnt - 3'd1;
          ST_RX_BYTE: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) rdata_q <= rx_byte;
          end
          ST_ACK_RX: begin
            if (!nack_q) begin
              phase <= phase + 2'd1;
              if (phase == 2'd0)              tx_byte <= addr_q;
              else if (phase == 2'd1 && !rw_q) tx_byte <= wdata_q;
            end
          end
          ST_RSTART: tx_byte <= bus_id(id_q, READ_OP);
          default: ;
        endcase
      end
    end
  end

  // Pad levels decoded from state and quarter, before the output register
  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = 1'b1;
    case (state)
      ST_START: begin
        sda_nxt = (qtr < 2'd2);
        scl_nxt = (qtr != 2'd3);
      end
      ST_RSTART: begin
        sda_nxt = (qtr < 2'd2);
        scl_nxt = scl_mid;
      end
      ST_TX_BYTE: begin
        sda_nxt = tx_byte[bit_cnt];
        scl_nxt = scl_mid;
      end
      ST_ACK_RX, ST_RX_BYTE, ST_NACK_TX: scl_nxt = scl_mid;
      ST_STOP: begin
        sda_nxt = qtr[1];
        scl_nxt = (qtr != 2'd0);
      end
      default: ;
    endcase
  end

  // Registered pad drivers so the open-drain enables never glitch; reset releases both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_t <= 1'b1;
      sda_t <= 1'b1;
    end else begin
      scl_t <= scl_nxt;
      sda_t <= sda_nxt;
    end
  end

  assign io.IO_RDATA_RDATA   = rdata_q;
  assign io.IO_CONTROL_CMPLT = (state == ST_DONE);
  assign io.busy             = (state != ST_IDLE) && (state != ST_DONE);
  assign io.ack_err          = ack_err_q;

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// Testbench for i2c_cmd_engine with CLK_DIV=4 and a behavioural I2C target.
// Build with I2C_CLK_STRETCH_EN defined to also run the clock-stretch scenario.
module tb_i2c_cmd_engine;
  import i2c_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;
  localparam int EV_MACK  = 768;
  localparam int WR_LAT   = 1 + 116 * CLK_DIV;
  localparam int RD_LAT   = 1 + 156 * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_t, sda_t, scl_i, sda_i;
  i2c_cmd_engine_if bus_if ();

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int cmplt_cnt = 0;
  int exp_q[$];
  int obs_q[$];

  // Target model state
  typedef enum {M_IDLE, M_RX, M_ACK, M_TX, M_MACK} mstate_t;
  mstate_t    mst;
  logic       model_sda;
  logic       pull;
  logic       pscl, psda, bsda;
  logic       first_byte, reading, acked;
  logic [7:0] sh;
  int         bitn, byten, stretch_left, stretch_seen;
  logic [7:0] rd_byte = 8'h00;
  int         nack_at = -1;
  int         stretch_req = 0;

  assign sda_i = sda_t & model_sda;
  assign scl_i = scl_t & ~pull;

  i2c_cmd_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_if.slave),
    .scl_t (scl_t),
    .sda_t (sda_t),
    .scl_i (scl_i),
    .sda_i (sda_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (bus_if.IO_CONTROL_CMPLT) cmplt_cnt++;

  // I2C target: logs START/STOP/bytes/master-ack, ACKs or NACKs, returns rd_byte
  always @(negedge clk) begin
    if (!rst_n) begin
      mst = M_IDLE; model_sda = 1'b1; pull = 1'b0; pscl = 1'b1; psda = 1'b1;
      bitn = 0; byten = 0; first_byte = 1'b0; reading = 1'b0; acked = 1'b0;
      sh = 8'h00; stretch_left = 0;
    end else begin
      bsda = sda_t & model_sda;
      if (pscl && scl_t && psda && !bsda) begin
        obs_q.push_back(EV_START);
        mst = M_RX; bitn = 0; first_byte = 1'b1;
      end else if (pscl && scl_t && !psda && bsda) begin
        obs_q.push_back(EV_STOP);
        mst = M_IDLE; byten = 0; model_sda = 1'b1;
      end else if (!pscl && scl_t) begin
        if (mst == M_RX) begin
          sh = {sh[6:0], bsda};
          bitn++;
        end else if (mst == M_MACK) begin
          obs_q.push_back(EV_MACK | int'(bsda));
        end
      end else if (pscl && !scl_t) begin
        case (mst)
          M_RX: if (bitn == 8) begin
            obs_q.push_back(int'(sh));
            if (first_byte) reading = sh[0];
            first_byte = 1'b0;
            acked = (byten != nack_at);
            model_sda = !acked;
            byten++;
            mst = M_ACK;
          end
          M_ACK: begin
            model_sda = 1'b1;
            bitn = 0;
            if (acked && reading) begin
              mst = M_TX;
              model_sda = rd_byte[7];
            end else begin
              mst = M_RX;
            end
          end
          M_TX: begin
            bitn++;
            if (bitn == 8) begin
              model_sda = 1'b1;
              mst = M_MACK;
            end else begin
              model_sda = rd_byte[3'(7 - bitn)];
            end
          end
          M_MACK: mst = M_IDLE;
          default: ;
        endcase
      end
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) pull = 1'b0;
      end else if (stretch_req > stretch_seen && mst == M_ACK && scl_t) begin
        stretch_seen++;
        pull = 1'b1;
        stretch_left = 50;
      end
      pscl = scl_t;
      psda = sda_t & model_sda;
    end
  end

  // Drives one request at a negedge and pushes the expected bus traffic
  task automatic applyStimulus(input logic rw, input logic [7:0] id, input logic [7:0] addr,
                               input logic [7:0] wdata, input int nack_byte, output int start_cyc);
    @(negedge clk);
    nack_at = nack_byte;
    bus_if.IO_CONTROL_RW    = rw;
    bus_if.IO_CONTROL_ID    = id;
    bus_if.IO_ADDR_ADDR     = addr;
    bus_if.IO_WDATA_WDATA   = wdata;
    bus_if.IO_CONTROL_PULSE = 1'b1;
    start_cyc = cyc;
    exp_q.push_back(EV_START);
    exp_q.push_back(int'({id[7:1], 1'b0}));
    if (nack_byte != 0) begin
      exp_q.push_back(int'(addr));
      if (nack_byte != 1) begin
        if (rw) begin
          exp_q.push_back(EV_START);
          exp_q.push_back(int'({id[7:1], 1'b1}));
          if (nack_byte != 2) exp_q.push_back(EV_MACK | 1);
        end else begin
          exp_q.push_back(int'(wdata));
        end
      end
    end
    exp_q.push_back(EV_STOP);
    @(negedge clk);
    bus_if.IO_CONTROL_PULSE = 1'b0;
  endtask

  // Waits (bounded) for the completion pulse
  task automatic wait_done(output int done_cyc, output bit timed_out);
    timed_out = 1'b1;
    done_cyc  = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus_if.IO_CONTROL_CMPLT) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.IO_CONTROL_PULSE = 1'b0;
    bus_if.IO_CONTROL_RW    = 1'b0;
    bus_if.IO_CONTROL_ID    = 8'h00;
    bus_if.IO_ADDR_ADDR     = 8'h00;
    bus_if.IO_WDATA_WDATA   = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_if.IO_RDATA_RDATA !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rdata got %h expected 00", bus_if.IO_RDATA_RDATA); end
    n_cmp++; if (bus_if.IO_CONTROL_CMPLT !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmplt got %b expected 0", bus_if.IO_CONTROL_CMPLT); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b expected 0", bus_if.busy); end
    n_cmp++; if (bus_if.ack_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack_err got %b expected 0", bus_if.ack_err); end
    n_cmp++; if (scl_t !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_scl_t got %b expected 1", scl_t); end
    n_cmp++; if (sda_t !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sda_t got %b expected 1", sda_t); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int s, d, e, o;
    bit to;
    applyStimulus(WRITE_OP, ID_PWR_EXP, 8'h03, 8'h55, -1, s);
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL write_busy_rise got %b expected 1", bus_if.busy); end
    wait_done(d, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL write_timeout got no CMPLT expected CMPLT"); end
    n_cmp++; if (d - s !== WR_LAT) begin n_fail++; $display("[TB] FAIL write_latency got %0d expected %0d", d - s, WR_LAT); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL write_busy_at_done got %b expected 0", bus_if.busy); end
    n_cmp++; if (bus_if.ack_err !== 1'b0) begin n_fail++; $display("[TB] FAIL write_ack_err got %b expected 0", bus_if.ack_err); end
    @(negedge clk);
    n_cmp++; if (bus_if.IO_CONTROL_CMPLT !== 1'b0) begin n_fail++; $display("[TB] FAIL write_cmplt_width got %b expected 0", bus_if.IO_CONTROL_CMPLT); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL write_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL write_bus got %h expected %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL write_bus_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_read();
    int s, d, e, o;
    bit to;
    rd_byte = 8'h11;
    applyStimulus(READ_OP, ID_QSFP_EEP, 8'h00, 8'h00, -1, s);
    wait_done(d, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL read_timeout got no CMPLT expected CMPLT"); end
    n_cmp++; if (d - s !== RD_LAT) begin n_fail++; $display("[TB] FAIL read_latency got %0d expected %0d", d - s, RD_LAT); end
    n_cmp++; if (bus_if.IO_RDATA_RDATA !== 8'h11) begin n_fail++; $display("[TB] FAIL read_rdata got %h expected 11", bus_if.IO_RDATA_RDATA); end
    n_cmp++; if (bus_if.ack_err !== 1'b0) begin n_fail++; $display("[TB] FAIL read_ack_err got %b expected 0", bus_if.ack_err); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL read_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL read_bus got %h expected %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL read_bus_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_nack();
    int s, d, e, o;
    bit to;
    rd_byte = 8'h77;
    applyStimulus(READ_OP, ID_QSFP_EEP, 8'h05, 8'h00, 1, s);
    wait_done(d, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL nack_timeout got no CMPLT expected CMPLT"); end
    n_cmp++; if (bus_if.ack_err !== 1'b1) begin n_fail++; $display("[TB] FAIL nack_ack_err got %b expected 1", bus_if.ack_err); end
    n_cmp++; if (bus_if.IO_RDATA_RDATA !== 8'h11) begin n_fail++; $display("[TB] FAIL nack_rdata_kept got %h expected 11", bus_if.IO_RDATA_RDATA); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL nack_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL nack_bus got %h expected %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL nack_bus_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
    applyStimulus(WRITE_OP, ID_MUX_A, 8'h01, 8'h02, -1, s);
    n_cmp++; if (bus_if.ack_err !== 1'b0) begin n_fail++; $display("[TB] FAIL nack_clear_on_accept got %b expected 0", bus_if.ack_err); end
    wait_done(d, to);
    n_cmp++; if (to || bus_if.ack_err !== 1'b0) begin n_fail++; $display("[TB] FAIL nack_recover got to=%b ack_err=%b expected 0/0", to, bus_if.ack_err); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL nack_recover_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL nack_recover_bus got %h expected %h", o, e); end end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int s, d, e, o, base;
    bit to;
    base = cmplt_cnt;
    applyStimulus(WRITE_OP, ID_MUX_B, 8'h10, 8'hA5, -1, s);
    repeat (100) @(negedge clk);
    bus_if.IO_CONTROL_RW    = READ_OP;
    bus_if.IO_CONTROL_ID    = ID_QSFP_SB;
    bus_if.IO_ADDR_ADDR     = 8'h77;
    bus_if.IO_WDATA_WDATA   = 8'h3C;
    bus_if.IO_CONTROL_PULSE = 1'b1;
    @(negedge clk);
    bus_if.IO_CONTROL_PULSE = 1'b0;
    wait_done(d, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL busy_pulse_timeout got no CMPLT expected CMPLT"); end
    n_cmp++; if (d - s !== WR_LAT) begin n_fail++; $display("[TB] FAIL busy_pulse_latency got %0d expected %0d", d - s, WR_LAT); end
    repeat (60) @(negedge clk);
    n_cmp++; if (cmplt_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL busy_pulse_cmplt_count got %0d expected 1", cmplt_cnt - base); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_pulse_idle got %b expected 0", bus_if.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL busy_pulse_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL busy_pulse_bus got %h expected %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL busy_pulse_bus_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int s, d, e, o;
    bit to;
    applyStimulus(WRITE_OP, ID_QSFP_SB, 8'h22, 8'h33, -1, s);
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (scl_t !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_scl_t got %b expected 1", scl_t); end
    n_cmp++; if (sda_t !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_sda_t got %b expected 1", sda_t); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got %b expected 0", bus_if.busy); end
    exp_q.delete();
    exp_q.push_back(EV_START);
    exp_q.push_back(int'(ID_QSFP_SB));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL midreset_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL midreset_bus got %h expected %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_no_stop got %0d events expected 0", obs_q.size()); obs_q.delete(); end
    applyStimulus(WRITE_OP, ID_MUX_B, 8'h01, 8'h0F, -1, s);
    wait_done(d, to);
    n_cmp++; if (to || d - s !== WR_LAT) begin n_fail++; $display("[TB] FAIL midreset_recover_latency got %0d expected %0d", d - s, WR_LAT); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL midreset_recover_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL midreset_recover_bus got %h expected %h", o, e); end end
    end
    obs_q.delete();
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int s, d, e, o;
    bit to;
    stretch_req = stretch_seen + 1;
    applyStimulus(WRITE_OP, ID_PWR_EXP, 8'h03, 8'h55, -1, s);
    wait_done(d, to);
    n_cmp++; if (to || d - s !== WR_LAT + 50) begin n_fail++; $display("[TB] FAIL stretch_latency got %0d expected %0d", d - s, WR_LAT + 50); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL stretch_bus got none expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("[TB] FAIL stretch_bus got %h expected %h", o, e); end end
    end
    obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got no finish expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
